// File: rtl/jstk_spi_slave.sv
// rtl/jstk_spi_slave.sv - PmodJSTK-compatible SPI mode-0 slave, oversampled on the system clock
module jstk_spi_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [5:0]  CMD_PREFIX  = 6'b100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [2:0]  buttons,
    output logic [1:0]  led,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
    logic                   ss_prev, sclk_prev;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [39:0] tx;
    logic [39:0] frame;
    logic [7:0]  rx, rx_next, cmd;
    logic [5:0]  bit_cnt;

    // SS chain resets low so an SS already low at reset release is not seen as a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
        end
    end

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = ~sclk_prev & sclk_s;
    assign sclk_fall = sclk_prev & ~sclk_s;

    assign frame   = {pos_x[7:0], 6'b0, pos_x[9:8], pos_y[7:0], 6'b0, pos_y[9:8], 5'b0, buttons};
    assign rx_next = {rx[6:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ss_fall) state_n = LOAD;
            LOAD:    state_n = SHIFT;
            SHIFT:   if (ss_rise) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx         <= '0;
            rx         <= '0;
            cmd        <= '0;
            bit_cnt    <= '0;
            MISO       <= 1'b0;
            led        <= 2'b00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    busy <= 1'b0;
                end
                LOAD: begin
                    tx      <= frame;
                    MISO    <= frame[39];
                    bit_cnt <= '0;
                    cmd     <= '0;
                    rx      <= '0;
                    busy    <= 1'b1;
                end
                SHIFT: begin
                    // An SS rise in the same clk as an SCLK edge ends the frame; the edge is dropped
                    if (!ss_rise) begin
                        if (sclk_rise) begin
                            rx <= rx_next;
                            if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) cmd <= rx_next;
                        end else if (sclk_fall) begin
                            tx   <= {tx[38:0], 1'b0};
                            MISO <= tx[38];
                        end
                    end
                end
                DONE: begin
                    if (bit_cnt == 6'd40) begin
                        frame_done <= 1'b1;
                        if (cmd[7:2] == CMD_PREFIX) led <= cmd[1:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                    busy <= 1'b0;
                    MISO <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    MISO <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/jstk_spi_slave.md
Name: jstk_spi_slave

Overview:
- SPI mode-0 responder that emulates the PmodJSTK joystick: the slave end of the link driven by the PmodJSTK SPI master.
- Serves a 40-bit joystick frame (X, Y, buttons) on MISO and decodes the master's command byte to drive two LED outputs.
- Used as a board-side joystick emulator and as a loopback target for the stopwatch joystick path.
- Runs entirely on the 100 MHz system clock; SS, SCLK and MOSI are oversampled, not used as clocks.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SS/SCLK/MOSI (must be >=2).
- CMD_PREFIX, 6'b100000, value required in command bits [7:2] for an LED update.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- SS  in  1  slave select from the master, active low.
- SCLK  in  1  serial clock from the master, idle low.
- MOSI  in  1  master-to-slave data.
- MISO  out  1  slave-to-master data.
- pos_x  in  10  joystick X position; sampled at frame start.
- pos_y  in  10  joystick Y position; sampled at frame start.
- buttons  in  3  button states {btn2,btn1,btn0}; sampled at frame start.
- led  out  2  LED state from the last valid command.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-clk pulse after a complete 40-bit frame.
- frame_err  out  1  one-clk pulse when SS deasserts with a bit count other than 40.

Behaviour:
- Reset values: MISO=0, led=2'b00, busy=0, frame_done=0, frame_err=0, bit counter=0, shift registers=0, FSM=IDLE.
- Synchronizers: SS, SCLK and MOSI each pass through SYNC_STAGES flops. Edge detect uses the last synchronized sample and the previous one.
- Timing requirement: the SCLK high and low phases are each >=6 clk. The master's SS-fall-to-first-SCLK-rise gap is >=6 clk.
- Frame format (MSB first, byte 0 first):
  - byte0 = pos_x[7:0]
  - byte1 = {6'b0, pos_x[9:8]}
  - byte2 = pos_y[7:0]
  - byte3 = {6'b0, pos_y[9:8]}
  - byte4 = {5'b0, buttons}
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - MISO=0, busy=0.
  - On a synchronized SS falling edge, go to LOAD.
- LOAD (one clk):
  - Snapshot pos_x, pos_y and buttons into the 40-bit tx register.
  - Drive MISO = tx[39]; clear the bit counter and the 8-bit cmd register.
  - Set busy=1; go to SHIFT.
  - Input changes after LOAD do not affect the current frame.
- SHIFT, on SCLK rising edge:
  - Shift MOSI into the rx shift register.
  - Increment the bit counter, saturating at 63.
  - When the counter reaches 8, copy rx into cmd.
- SHIFT, on SCLK falling edge:
  - Shift tx left with zero fill; MISO = new tx[39].
  - After 40 bits MISO stays 0 for any extra clocks.
- SHIFT, on SS rising edge: go to DONE.
- DONE (one clk):
  - If the bit count is exactly 40: pulse frame_done. If also cmd[7:2]==CMD_PREFIX, led <= cmd[1:0].
  - If the bit count is not 40: pulse frame_err; led is unchanged.
  - Set busy=0, MISO=0; go to IDLE.
- Simultaneous SCLK edge and SS rise in the same clk: the SS rise wins and that SCLK edge is ignored.
- SCLK edges while SS is high are ignored.
- SS falling while in DONE is taken on the next clk in IDLE. Nothing is lost, because the gap requirement gives margin.
- Reset asserted mid-frame: all state clears immediately. After release the FSM waits in IDLE for the next SS falling edge, even if SS is already low.
- Latency: MISO follows SCLK falling by SYNC_STAGES+1 clk. This is well inside the half-period requirement.

Test Plan:
- pos_x=10'h2A5, pos_y=10'h13C, buttons=3'b101, master sends 40 clocks with cmd 8'h83 -> master receives 40'hA5_02_3C_01_05; led=2'b11; frame_done pulses once; frame_err=0.
- Same frame with cmd 8'h00 -> data is correct and frame_done pulses; led keeps its previous value 2'b11.
- pos_x changes from 10'h000 to 10'h3FF in the middle of a frame -> the current frame returns X bytes 00_00; the next frame returns FF_03.
- SS raised after 20 bits with cmd 8'h82 -> frame_err pulses; frame_done=0; led is unchanged; the next full frame is correct.
- 48 SCLK clocks in one frame -> the last 8 bits on MISO are 0; frame_err pulses; led is unchanged.
- rst asserted at bit 15 -> MISO=0, busy=0 and led=00 within 1 clk. The next SS-low frame is fully correct.
